// File: rtl/uart_tx_port_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_port_if
// Purpose  : CPU-side write/status bundle for the uart_tx_port peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_port_if;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_ovf;
    logic        tx;
    logic [31:0] status;

    modport master (output wr_en, output wr_data, output clr_ovf, input tx, input status);
    modport slave  (input wr_en, input wr_data, input clr_ovf, output tx, output status);
endinterface
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_port
// Purpose  : FIFO-buffered UART transmitter (8N1, or 8E1 when the macro
//            UART_TX_PARITY_EN is defined) with a pollable status word.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
    parameter int CLK_HZ = 23_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_tx_port_if.slave    bus
);
    localparam int c_DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_CW  = c_AW + 1;
    localparam int c_TW  = $clog2(c_DIV);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
`endif

    logic       w_empty;
    logic       w_full;
    logic       w_tick;
    logic       w_pop;
    logic       w_push;
    logic       w_ovf_evt;
    logic       w_busy;
    logic [7:0] w_head;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_tick    = (r_timer == c_TLAST);
    assign w_busy    = (r_state != S_IDLE);
    assign w_head    = r_mem[r_rd_ptr];
    // A pop happens when idle, or exactly on the last stop-bit cycle so frames abut.
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_tick));
    assign w_push    = bus.wr_en && (!w_full || w_pop);
    assign w_ovf_evt = bus.wr_en && w_full && !w_pop;

    assign bus.tx     = r_tx;
    assign bus.status = {20'b0, 4'(r_count), 4'b0, r_ovf, w_empty, w_full, w_busy};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh overflow wins over a simultaneous clear.
            if (w_ovf_evt)        r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    r_tx    <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_par   <= ^w_head;
`endif
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
